// File: rtl/disp_pkg.sv
// Shared types and constants for the two-requester display sharing controller.
// DISP_SWAP_GAP_EN adds the blank GAP state between owners.
package disp_pkg;

    localparam int unsigned HOLD_W = 8;
    localparam int unsigned NIB_W  = 4;

    localparam logic [NIB_W-1:0] BLANK_NIBBLE = 4'hF;

    // Four display digits; d3 occupies [15:12], d0 occupies [3:0].
    typedef struct packed {
        logic [NIB_W-1:0] d3;
        logic [NIB_W-1:0] d2;
        logic [NIB_W-1:0] d1;
        logic [NIB_W-1:0] d0;
    } disp_digits_t;

`ifdef DISP_SWAP_GAP_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2,
        ST_GAP  = 2'd3
    } disp_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } disp_state_e;
`endif

endpackage

// File: rtl/disp_share_ctrl_if.sv
// Request/data/display bundle between the two requesters and the sharing controller.
interface disp_share_ctrl_if;
    import disp_pkg::*;

    logic             req0;
    logic             req1;
    disp_digits_t     data0;
    disp_digits_t     data1;
    logic [NIB_W-1:0] hex3;
    logic [NIB_W-1:0] hex2;
    logic [NIB_W-1:0] hex1;
    logic [NIB_W-1:0] hex0;
    logic [1:0]       gnt;
    logic             tick;

    modport master (
        output req0, req1, data0, data1,
        input  hex3, hex2, hex1, hex0, gnt, tick
    );

    modport slave (
        input  req0, req1, data0, data1,
        output hex3, hex2, hex1, hex0, gnt, tick
    );

endinterface

// File: rtl/disp_tick_gen.sv
// Free-running prescaler; tick pulses for one cycle after the count reads all-ones.
module disp_tick_gen #(
    parameter int unsigned PRESC_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    output logic               tick,
    output logic [PRESC_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            count <= count + PRESC_W'(1);
            tick  <= &count;
        end
    end

endmodule

// File: rtl/disp_share_ctrl.sv
// Arbitrates one 4-digit display between two requesters with a minimum hold time.
// Define DISP_SWAP_GAP_EN to blank the display for one tick period on each handover.
module disp_share_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned PRESC_W = 24,
    parameter int unsigned HOLD    = 4
) (
    input  logic             clk,
    input  logic             rst,
    disp_share_ctrl_if.slave bus
);

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD);

    // Owner-to-owner handovers route through GAP when it exists.
`ifdef DISP_SWAP_GAP_EN
    localparam disp_state_e TO_OWN0 = ST_GAP;
    localparam disp_state_e TO_OWN1 = ST_GAP;
`else
    localparam disp_state_e TO_OWN0 = ST_OWN0;
    localparam disp_state_e TO_OWN1 = ST_OWN1;
`endif

    logic               tick;
    logic [PRESC_W-1:0] presc_cnt_unused;

    disp_state_e        state_q;
    disp_state_e        state_d;
    logic [HOLD_W-1:0]  hold_q;
    logic               last_q;
    logic [1:0]         gnt_q;
    logic [1:0]         gnt_d;
    disp_digits_t       hex_q;
    disp_digits_t       hex_d;

`ifdef DISP_SWAP_GAP_EN
    logic               gap_tgt_q;
    logic               gap_seen_q;
`endif

    disp_tick_gen #(
        .PRESC_W (PRESC_W)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .count (presc_cnt_unused)
    );

    // Next-state and next-output decode; outputs follow the state being entered.
    always_comb begin
        state_d = state_q;
        gnt_d   = 2'b00;
        hex_d   = '{default: BLANK_NIBBLE};

        case (state_q)
            ST_IDLE: begin
                if (bus.req0 && bus.req1) state_d = last_q ? ST_OWN0 : ST_OWN1;
                else if (bus.req0)        state_d = ST_OWN0;
                else if (bus.req1)        state_d = ST_OWN1;
            end
            ST_OWN0: begin
                if (!bus.req0)                            state_d = bus.req1 ? TO_OWN1 : ST_IDLE;
                else if (bus.req1 && hold_q == HOLD_MAX)  state_d = TO_OWN1;
            end
            ST_OWN1: begin
                if (!bus.req1)                            state_d = bus.req0 ? TO_OWN0 : ST_IDLE;
                else if (bus.req0 && hold_q == HOLD_MAX)  state_d = TO_OWN0;
            end
`ifdef DISP_SWAP_GAP_EN
            ST_GAP: begin
                if (gap_seen_q) begin
                    if (gap_tgt_q ? bus.req1 : bus.req0)      state_d = gap_tgt_q ? ST_OWN1 : ST_OWN0;
                    else if (gap_tgt_q ? bus.req0 : bus.req1) state_d = gap_tgt_q ? ST_OWN0 : ST_OWN1;
                    else                                      state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_OWN0: begin
                gnt_d = 2'b01;
                hex_d = bus.data0;
            end
            ST_OWN1: begin
                gnt_d = 2'b10;
                hex_d = bus.data1;
            end
            default: ;
        endcase
    end

    // State, hold counter, round-robin pointer and display registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= 2'b00;
            hex_q   <= '{default: BLANK_NIBBLE};
            hold_q  <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            hex_q   <= hex_d;
            if (state_d != state_q) begin
                hold_q <= '0;
            end else if ((state_q == ST_OWN0 || state_q == ST_OWN1) && tick && hold_q < HOLD_MAX) begin
                hold_q <= hold_q + HOLD_W'(1);
            end
            if (state_d == ST_OWN0)      last_q <= 1'b0;
            else if (state_d == ST_OWN1) last_q <= 1'b1;
        end
    end

`ifdef DISP_SWAP_GAP_EN
    // GAP ends on the edge after the first tick seen while already in GAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_tgt_q  <= 1'b0;
            gap_seen_q <= 1'b0;
        end else begin
            if (state_d == ST_GAP && state_q != ST_GAP) gap_tgt_q <= (state_q == ST_OWN0);
            gap_seen_q <= (state_q == ST_GAP) && (state_d == ST_GAP) && (gap_seen_q || tick);
        end
    end
`endif

    assign bus.gnt  = gnt_q;
    assign bus.hex3 = hex_q.d3;
    assign bus.hex2 = hex_q.d2;
    assign bus.hex1 = hex_q.d1;
    assign bus.hex0 = hex_q.d0;
    assign bus.tick = tick;

endmodule

// File: tb/tb_disp_share_ctrl.sv
// Directed plus randomized bench for disp_share_ctrl with an ownership-level reference model.
module tb_disp_share_ctrl;

    localparam int unsigned PRESC_W = 2;
    localparam int unsigned HOLD    = 3;
    localparam int          PERIOD  = 1 << PRESC_W;

    logic clk = 1'b0;
    logic rst = 1'b1;

    disp_share_ctrl_if bus ();

    disp_share_ctrl #(
        .PRESC_W (PRESC_W),
        .HOLD    (HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: owner -1 idle, 0/1 requester, 2 blank gap; k = cycles since reset release.
    int          m_own;
    int          m_held;
    int          m_last;
    int          m_tgt;
    int          m_k;
    bit          m_seen;
    logic [1:0]  m_gnt;
    logic [15:0] m_hex;
    logic        m_tick;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_own  = -1;
        m_held = 0;
        m_last = 1;
        m_tgt  = 0;
        m_k    = 0;
        m_seen = 1'b0;
        m_gnt  = 2'b00;
        m_hex  = 16'hFFFF;
        m_tick = 1'b0;
    endtask

    task automatic model_step(input bit r0, input bit r1, input logic [15:0] d0, input logic [15:0] d1);
        bit r [2];
        bit tk;
        int nxt;
        r[0] = r0;
        r[1] = r1;
        tk   = (m_k != 0) && (m_k % PERIOD == 0);
        nxt  = m_own;
        if (m_own == -1) begin
            if (r0 && r1)  nxt = 1 - m_last;
            else if (r0)   nxt = 0;
            else if (r1)   nxt = 1;
        end else if (m_own == 2) begin
            if (m_seen)    nxt = r[m_tgt] ? m_tgt : (r[1-m_tgt] ? 1 - m_tgt : -1);
            else if (tk)   m_seen = 1'b1;
        end else begin
            if (!r[m_own])                               nxt = r[1-m_own] ? 1 - m_own : -1;
            else if (r[1-m_own] && m_held == int'(HOLD)) nxt = 1 - m_own;
        end
`ifdef DISP_SWAP_GAP_EN
        if ((m_own == 0 || m_own == 1) && nxt == 1 - m_own) begin
            m_tgt  = nxt;
            nxt    = 2;
            m_seen = 1'b0;
        end
`endif
        if (nxt != m_own) m_held = 0;
        else if ((m_own == 0 || m_own == 1) && tk && m_held < int'(HOLD)) m_held++;
        if (nxt != 2) m_seen = 1'b0;
        if (nxt == 0 || nxt == 1) m_last = nxt;
        m_own  = nxt;
        m_k++;
        m_gnt  = (nxt == 0) ? 2'b01 : (nxt == 1) ? 2'b10 : 2'b00;
        m_hex  = (nxt == 0) ? d0 : (nxt == 1) ? d1 : 16'hFFFF;
        m_tick = (m_k % PERIOD == 0);
    endtask

    function automatic logic [15:0] hex_all();
        return {bus.hex3, bus.hex2, bus.hex1, bus.hex0};
    endfunction

    // Drive at the falling edge, advance one clock, compare against the model at the next falling edge.
    task automatic cycle(input bit r0, input bit r1, input logic [15:0] d0, input logic [15:0] d1);
        bus.req0  = r0;
        bus.req1  = r1;
        bus.data0 = d0;
        bus.data1 = d1;
        @(posedge clk);
        if (rst) model_reset();
        else     model_step(r0, r1, d0, d1);
        @(negedge clk);
        chk("gnt",  16'(bus.gnt),  16'(m_gnt));
        chk("hex",  hex_all(),     m_hex);
        chk("tick", 16'(bus.tick), 16'(m_tick));
    endtask

    // Assert reset mid-cycle and confirm the outputs clear without waiting for a clock edge.
    task automatic async_reset();
        rst = 1'b1;
        #1;
        chk("arst_gnt",  16'(bus.gnt),  16'h0000);
        chk("arst_hex",  hex_all(),     16'hFFFF);
        chk("arst_tick", 16'(bus.tick), 16'h0000);
        model_reset();
        @(negedge clk);
        cycle(1'b0, 1'b0, 16'h0, 16'h0);
        cycle(1'b1, 1'b1, 16'h0, 16'h0);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int gap_samples;
        bit r0;
        bit r1;

        model_reset();
        bus.req0  = 1'b0;
        bus.req1  = 1'b0;
        bus.data0 = 16'h0;
        bus.data1 = 16'h0;
        @(negedge clk);
        chk("rst_gnt",  16'(bus.gnt),  16'h0000);
        chk("rst_hex",  hex_all(),     16'hFFFF);
        chk("rst_tick", 16'(bus.tick), 16'h0000);
        cycle(1'b0, 1'b0, 16'h0, 16'h0);
        rst = 1'b0;

        // Single owner with live data tracking, then release to idle.
        cycle(1'b1, 1'b0, 16'h1234, 16'hAAAA);
        chk("own0_gnt", 16'(bus.gnt), 16'h0001);
        chk("own0_hex", hex_all(),    16'h1234);
        cycle(1'b1, 1'b0, 16'h5678, 16'hAAAA);
        chk("live_hex", hex_all(),    16'h5678);
        cycle(1'b0, 1'b0, 16'h5678, 16'hAAAA);
        chk("idle_hex", hex_all(),    16'hFFFF);

        // First tie after reset goes to requester 0.
        async_reset();
        cycle(1'b1, 1'b1, 16'hC0DE, 16'hBEEF);
        chk("tie_gnt", 16'(bus.gnt), 16'h0001);

        // Contested handover only after HOLD ticks since the grant.
        async_reset();
        cycle(1'b1, 1'b0, 16'h1111, 16'h2222);
        n = 0;
        gap_samples = 0;
        while (bus.gnt != 2'b10 && n < 40) begin
            cycle(1'b1, 1'b1, 16'h1111, 16'h2222);
            n++;
            if (bus.gnt == 2'b00 && hex_all() == 16'hFFFF) gap_samples++;
        end
`ifdef DISP_SWAP_GAP_EN
        chk("contest_edges", 16'(n), 16'd17);
        chk("gap_cycles", 16'(gap_samples), 16'd4);
`else
        chk("contest_edges", 16'(n), 16'd13);
        chk("gap_cycles", 16'(gap_samples), 16'd0);
`endif

        // Early release with hold_cnt = 1.
        n = 0;
        while (m_held != 1 && n < 10) begin
            cycle(1'b1, 1'b1, 16'h3333, 16'h4444);
            n++;
        end
        chk("hold_one", 16'(m_held), 16'd1);
        cycle(1'b1, 1'b0, 16'h3333, 16'h4444);
`ifdef DISP_SWAP_GAP_EN
        chk("early_rel_gnt", 16'(bus.gnt), 16'h0000);
`else
        chk("early_rel_gnt", 16'(bus.gnt), 16'h0001);
`endif

        // Move to OWN1 and abort it with reset.
        n = 0;
        while (bus.gnt != 2'b10 && n < 12) begin
            cycle(1'b0, 1'b1, 16'h5555, 16'h6666);
            n++;
        end
        chk("reach_own1", 16'(bus.gnt), 16'h0002);
        async_reset();

        // Randomized sticky requests with live data and occasional resets.
        r0 = 1'b0;
        r1 = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 6) == 0) r0 = ~r0;
            if ($urandom_range(0, 6) == 0) r1 = ~r1;
            rst = ($urandom_range(0, 299) == 0);
            cycle(r0, r1, 16'($urandom), 16'($urandom));
        end
        rst = 1'b0;
        cycle(1'b0, 1'b0, 16'h0, 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/disp_share_ctrl.md
DISP_SHARE_CTRL -- requirements
Module: disp_share_ctrl

Interface
REQ-001 Parameter PRESC_W, default 24: prescaler width; one tick every 2^PRESC_W clk cycles.
REQ-002 Parameter HOLD, default 4: minimum ticks an owner keeps the display before a contested handover, range 1..255.
REQ-003 clk  in  1  system clock; all state changes on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req0, req1  in  1 each  display request from requester 0 and requester 1.
REQ-006 data0, data1  in  16 each  four nibbles per requester; [15:12] is digit 3, [3:0] is digit 0.
REQ-007 hex3, hex2, hex1, hex0  out  4 each  registered nibbles for the display multiplexer.
REQ-008 gnt  out  2  registered one-hot grant; 00 when idle.
REQ-009 tick  out  1  registered single-cycle prescaler pulse.

Function
REQ-010 The prescaler shall be a free-running PRESC_W-bit counter that wraps to 0 after all-ones.
REQ-011 The tick output shall be high for exactly one cycle, in the cycle after the prescaler reads all-ones.
REQ-012 The FSM shall have states IDLE, OWN0 and OWN1 (plus GAP, see Configuration).
REQ-013 IDLE: with exactly one requester asserted, the FSM shall move to that requester's OWN state on the next edge; with none asserted, it shall stay in IDLE.
REQ-014 IDLE, both requesters asserted: the grant shall go to the requester that is not last_owner (round-robin).
REQ-015 OWNx, own request still asserted, other not requesting: the FSM shall stay in OWNx; hold_cnt shall saturate at HOLD.
REQ-016 OWNx, own request still asserted, other requesting: the FSM shall switch to the other requester on the edge after hold_cnt == HOLD; until then it shall stay in OWNx.
REQ-017 OWNx, own request deasserted: the FSM shall release on the next edge, regardless of hold_cnt, to the other requester if it is requesting, otherwise to IDLE.
REQ-018 hold_cnt shall be 8 bits, clear to 0 on every grant change, and increment on tick while in an OWN state.
REQ-019 last_owner shall update on every entry into OWN0 or OWN1.
REQ-020 gnt shall be 01 in OWN0, 10 in OWN1, and 00 in IDLE and GAP.
REQ-021 While in OWNx, hex3..hex0 shall be registered from datax every cycle: one-cycle latency, tracking live data.
REQ-022 In IDLE and GAP, hex3..hex0 shall be 4'hF (blank code).
REQ-023 gnt and hex shall change on the same edge; no cycle may show a new owner's gnt with the old owner's data.
REQ-024 A request edge arriving in the same cycle as a tick shall be handled exactly as in a cycle without a tick.

Reset
REQ-025 While rst is high: state = IDLE, gnt = 00, hex3..hex0 = 4'hF, tick = 0, prescaler = 0, hold_cnt = 0, last_owner = 1 (requester 0 wins the first tie).
REQ-026 rst asserted mid-ownership shall abort the grant immediately and asynchronously, with no glitch state retained.
REQ-027 After rst releases, the first grant shall follow REQ-013/REQ-014.

Configuration
REQ-028 Macro DISP_SWAP_GAP_EN shall control the blank gap between owners.
REQ-029 With DISP_SWAP_GAP_EN defined: every OWN0-to-OWN1 or OWN1-to-OWN0 handover shall pass through GAP for exactly one tick period.
REQ-030 GAP timing: the FSM shall enter GAP on the switch edge and leave it on the edge after the next tick; gnt = 00 and hex = F while in GAP.
REQ-031 GAP exit: if the target's request has dropped by then, the FSM shall go to the other requester if it is requesting, else to IDLE.
REQ-032 Without DISP_SWAP_GAP_EN: GAP shall not exist and handovers shall be direct per REQ-016/REQ-017.

Structure
REQ-033 Package disp_pkg shall hold the state enum type, constant BLANK_NIBBLE = 4'hF, and the HOLD width constant (8).
REQ-034 The prescaler shall be a sub-module named disp_tick_gen, with parameter PRESC_W and outputs tick and the raw count.
REQ-035 The arbitration FSM and output registers shall reside in disp_share_ctrl.

Verification (PRESC_W = 2, HOLD = 3)
REQ-036 Reset: rst pulse while in OWN1 -> next sample shows gnt = 00, all hex = F, tick = 0.
REQ-037 Single owner: req0 = 1, data0 = 16'h1234 -> gnt = 01 one edge later, hex3..0 = 1,2,3,4 on the same edge; data0 -> 16'h5678 shows one cycle later.
REQ-038 Tie after reset: req0 = req1 = 1 in the same cycle -> gnt = 01.
REQ-039 Held contest: req1 then rises -> gnt = 10 only on the edge after the third tick since the grant, not earlier.
REQ-040 Early release: owner drops req with hold_cnt = 1 -> grant passes (or goes to IDLE / hex = F) on the next edge.
REQ-041 DISP_SWAP_GAP_EN defined: contested handover -> gnt = 00 and hex = F for exactly one tick period (4 cycles), then gnt = 10.
